// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer: sequences one C = A x B multiply over a shared
// two-operand read port. It walks i (row of C), j (column of C) and k (inner
// index), accumulates signed products and emits one write per element of C.
// Optional build macro: MATRIX_SEQ_SATURATE_EN. When it is defined, results
// saturate to the signed SIZE_VALUE range. When it is not defined, results
// wrap to the low SIZE_VALUE bits.
module matrix_mult_sequencer #(
    parameter int WIDTH_LEN  = 3,
    parameter int SIZE_VALUE = 16,
    parameter int ACC_WIDTH  = 2*SIZE_VALUE+WIDTH_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH_LEN-1:0]         m_last,
    input  logic [WIDTH_LEN-1:0]         n_last,
    input  logic [WIDTH_LEN-1:0]         p_last,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [WIDTH_LEN-1:0]         rx1,
    output logic [WIDTH_LEN-1:0]         ry1,
    input  logic signed [SIZE_VALUE-1:0] rd_data1,
    output logic [WIDTH_LEN-1:0]         rx2,
    output logic [WIDTH_LEN-1:0]         ry2,
    input  logic signed [SIZE_VALUE-1:0] rd_data2,
    output logic                         wr_en,
    output logic [WIDTH_LEN-1:0]         wx,
    output logic [WIDTH_LEN-1:0]         wy,
    output logic signed [SIZE_VALUE-1:0] wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [WIDTH_LEN-1:0]         i_q, i_d;
    logic [WIDTH_LEN-1:0]         j_q, j_d;
    logic [WIDTH_LEN-1:0]         k_q, k_d;
    logic [WIDTH_LEN-1:0]         m_q, m_d;
    logic [WIDTH_LEN-1:0]         n_q, n_d;
    logic [WIDTH_LEN-1:0]         p_q, p_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         mac_valid_q;

    logic signed [2*SIZE_VALUE-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [SIZE_VALUE-1:0]   acc_conv;

    assign prod     = rd_data1 * rd_data2;
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef MATRIX_SEQ_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-SIZE_VALUE+1){1'b0}}, {(SIZE_VALUE-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-SIZE_VALUE+1){1'b1}}, {(SIZE_VALUE-1){1'b0}}};

    // Clamp the accumulator into the signed result range
    always_comb begin
        if (acc_q > SAT_MAX) begin
            acc_conv = SAT_MAX[SIZE_VALUE-1:0];
        end else if (acc_q < SAT_MIN) begin
            acc_conv = SAT_MIN[SIZE_VALUE-1:0];
        end else begin
            acc_conv = acc_q[SIZE_VALUE-1:0];
        end
    end
`else
    assign acc_conv = acc_q[SIZE_VALUE-1:0];
`endif

    // State, loop counters, latched dimensions, accumulator and MAC pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            acc_q       <= '0;
            mac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            m_q         <= m_d;
            n_q         <= n_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            mac_valid_q <= rd_en;
        end
    end

    // Next-state, loop walk and accumulate; outputs are decoded from state
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        m_d     = m_q;
        n_d     = n_q;
        p_d     = p_q;
        acc_d   = acc_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rx1     = '0;
        ry1     = '0;
        rx2     = '0;
        ry2     = '0;
        wr_en   = 1'b0;
        wx      = '0;
        wy      = '0;
        wr_data = '0;

        // Operand data arrives one cycle after its read.
        if (mac_valid_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = m_last;
                    n_d     = n_last;
                    p_d     = p_last;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                rx1   = k_q;
                ry1   = i_q;
                rx2   = j_q;
                ry2   = k_q;
                if (k_q == n_q) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wx      = j_q;
                wy      = i_q;
                wr_data = acc_conv;
                acc_d   = '0;
                if (i_q == m_q && j_q == p_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = '0;
                    state_d = S_RUN;
                    if (j_q == p_q) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// tb_matrix_mult_sequencer: cycle-by-cycle check of matrix_mult_sequencer
// against a schedule and product computed directly from the matrix definition.
module tb_matrix_mult_sequencer;

    localparam int WL = 3;
    localparam int SV = 16;
    localparam int DIM = 1 << WL;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WL-1:0]        m_last, n_last, p_last;
    logic                 busy, done, rd_en, wr_en;
    logic [WL-1:0]        rx1, ry1, rx2, ry2, wx, wy;
    logic signed [SV-1:0] rd_data1, rd_data2, wr_data;

    logic signed [SV-1:0] mat_a [DIM][DIM];
    logic signed [SV-1:0] mat_b [DIM][DIM];

    int n_checks = 0;
    int n_fail   = 0;

    matrix_mult_sequencer #(
        .WIDTH_LEN (WL),
        .SIZE_VALUE(SV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .m_last  (m_last),
        .n_last  (n_last),
        .p_last  (p_last),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rx1     (rx1),
        .ry1     (ry1),
        .rd_data1(rd_data1),
        .rx2     (rx2),
        .ry2     (ry2),
        .rd_data2(rd_data2),
        .wr_en   (wr_en),
        .wx      (wx),
        .wy      (wy),
        .wr_data (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared read port: data one cycle after rd_en, garbage otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mat_a[ry1][rx1];
            rd_data2 <= mat_b[ry2][rx2];
        end else begin
            rd_data1 <= SV'($urandom);
            rd_data2 <= SV'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SV-1:0] conv(input longint s);
        longint lo = -(longint'(1) << (SV-1));
        longint hi = (longint'(1) << (SV-1)) - 1;
        longint r  = s;
`ifdef MATRIX_SEQ_SATURATE_EN
        if (s > hi) r = hi;
        if (s < lo) r = lo;
`else
        if (lo > hi) r = 0;
`endif
        return r[SV-1:0];
    endfunction

    function automatic logic [63:0] all_outs();
        return {busy, done, rd_en, rx1, ry1, rx2, ry2, wr_en, wx, wy, wr_data};
    endfunction

    // One multiply: abort_at>0 asserts rst in that cycle, poke pulses start while busy
    task automatic run_mult(input int m, input int n, input int p,
                            input int abort_at, input bit poke);
        longint cref [DIM][DIM];
        int mm = m + 1;
        int nn = n + 1;
        int pp = p + 1;
        int total = mm * pp * (nn + 2) + 1;
        for (int i = 0; i < mm; i++) begin
            for (int j = 0; j < pp; j++) begin
                cref[i][j] = 0;
                for (int k = 0; k < nn; k++) begin
                    cref[i][j] += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
                end
            end
        end
        @(negedge clk);
        m_last = WL'(m);
        n_last = WL'(n);
        p_last = WL'(p);
        start  = 1'b1;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            start  = poke && ((c % 5 == 2 && c < total) || c == total);
            m_last = WL'($urandom);
            n_last = WL'($urandom);
            p_last = WL'($urandom);
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1 check_eq("reset_outs", all_outs(), '0);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk);
                    check_eq("post_reset", {busy, done, rd_en, wr_en}, '0);
                end
                return;
            end
            if (c < total) begin
                int e  = (c - 1) / (nn + 2);
                int ph = (c - 1) % (nn + 2);
                logic [WL-1:0] ei = WL'(e / pp);
                logic [WL-1:0] ej = WL'(e % pp);
                logic [WL-1:0] ek = WL'(ph);
                logic [63:0] exp_rd = '0;
                logic [63:0] exp_wr = '0;
                if (ph < nn) exp_rd = {1'b1, ek, ei, ej, ek};
                if (ph == nn + 1) exp_wr = {1'b1, ej, ei, conv(cref[e / pp][e % pp])};
                check_eq($sformatf("rd c%0d", c), {rd_en, rx1, ry1, rx2, ry2}, exp_rd);
                check_eq($sformatf("wr c%0d", c), {wr_en, wx, wy, wr_data}, exp_wr);
                check_eq($sformatf("busy/done c%0d", c), {busy, done}, 2'b10);
            end else if (c == total) begin
                check_eq("done_pulse", {busy, done, rd_en, wr_en}, 4'b0100);
            end else begin
                check_eq("idle_after", {busy, done, rd_en, wr_en}, '0);
            end
        end
        start = 1'b0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_a[r][c] = SV'($urandom);
                mat_b[r][c] = SV'($urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        m_last = '0;
        n_last = '0;
        p_last = '0;
        fill_random();
        #1 check_eq("reset_state", all_outs(), '0);
        @(negedge clk);
        check_eq("reset_hold", all_outs(), '0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle", all_outs(), '0);

        // 1x1x1 signed
        mat_a[0][0] = -16'sd3;
        mat_b[0][0] = 16'sd5;
        run_mult(0, 0, 0, 0, 1'b0);

        // 2x2x2 identity times [[1,2],[3,4]]
        mat_a[0][0] = 1; mat_a[0][1] = 0; mat_a[1][0] = 0; mat_a[1][1] = 1;
        mat_b[0][0] = 1; mat_b[0][1] = 2; mat_b[1][0] = 3; mat_b[1][1] = 4;
        run_mult(1, 1, 1, 0, 1'b0);

        // 2x3 times 3x2, distinct elements
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mat_a[r][c] = SV'(r * 3 + c + 1);
                mat_b[r][c] = SV'(10 * (r + 1) + c);
            end
        end
        run_mult(1, 2, 1, 0, 1'b0);

        // Overflow of the result width
        mat_a[0][0] = 16'sd32767; mat_a[0][1] = 16'sd32767;
        mat_b[0][0] = 16'sd32767; mat_b[1][0] = 16'sd32767;
        run_mult(0, 1, 0, 0, 1'b0);

        // Stray start pulses while busy and during done
        fill_random();
        run_mult(1, 2, 1, 0, 1'b1);

        // Reset during RUN, then a clean 1x1x1
        run_mult(1, 1, 1, 2, 1'b0);
        mat_a[0][0] = 16'sd7;
        mat_b[0][0] = -16'sd9;
        run_mult(0, 0, 0, 0, 1'b0);

        // Random dimensions and data, then the maximum size
        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_mult(int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, DIM - 1)),
                     int'($urandom_range(0, DIM - 1)), 0, 1'($urandom));
        end
        fill_random();
        run_mult(DIM - 1, DIM - 1, DIM - 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
